// File: rtl/cpu_stack_if.sv
// Handshake-free control/status bundle between the control unit and the hardware stack.
// Control unit drives the master side; the stack implements the slave side.
interface cpu_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
);
   localparam int AW = $clog2(DEPTH);

   logic             push;
   logic             pop;
   logic             hold;
   logic             clear_err;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic [AW:0]      count;

   modport master (
      output push, pop, hold, clear_err, d,
      input  q, empty, full, overflow, underflow, count
   );

   modport slave (
      input  push, pop, hold, clear_err, d,
      output q, empty, full, overflow, underflow, count
   );
endinterface

// File: rtl/cpu_stack.sv
// LIFO stack for a CPU: DEPTH x WIDTH array, registered pop data, sticky over/underflow flags.
// Latency: a pop is visible on q after the accepting edge (1 cycle); pushes readable next cycle.
// Backpressure: none; hold stalls all operations, push+pop together is a no-op.
module cpu_stack #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128
) (
   input  logic         clk,
   input  logic         reset,
   cpu_stack_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      count_r;
   logic [WIDTH-1:0] q_r;
   logic             overflow_r;
   logic             underflow_r;

   logic [AW-1:0]    sp;
   logic [AW-1:0]    sp_m1;
   logic             empty_w;
   logic             full_w;
   logic             push_req;
   logic             pop_req;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf_evt;
   logic             unf_evt;

   assign sp      = count_r[AW-1:0];
   assign sp_m1   = sp - AW'(1);
   assign empty_w = (count_r == '0);
   assign full_w  = (count_r == (AW+1)'(DEPTH));

   // A lone request only; simultaneous push and pop cancel each other.
   assign push_req = bus.push && !bus.pop && !bus.hold;
   assign pop_req  = bus.pop && !bus.push && !bus.hold;
   assign push_ok  = push_req && !full_w;
   assign pop_ok   = pop_req && !empty_w;
   assign ovf_evt  = push_req && full_w;
   assign unf_evt  = pop_req && empty_w;

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[sp] <= bus.d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r     <= '0;
         q_r         <= '0;
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         if (push_ok) begin
            count_r <= count_r + (AW+1)'(1);
         end else if (pop_ok) begin
            count_r <= count_r - (AW+1)'(1);
            q_r     <= mem[sp_m1];
         end else if (unf_evt) begin
            q_r     <= '0;
         end
         // A new error event wins over a coincident clear.
         overflow_r  <= ovf_evt || (overflow_r && !bus.clear_err);
         underflow_r <= unf_evt || (underflow_r && !bus.clear_err);
      end
   end

   assign bus.q         = q_r;
   assign bus.count     = count_r;
   assign bus.empty     = empty_w;
   assign bus.full      = full_w;
   assign bus.overflow  = overflow_r;
   assign bus.underflow = underflow_r;
endmodule

// File: tb/tb_cpu_stack.sv
// Self-checking bench for cpu_stack: directed scenarios plus random traffic against a queue model.
module tb_cpu_stack;
   localparam int WIDTH = 32;
   localparam int DEPTH = 128;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cpu_stack_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
   cpu_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   int compared = 0;
   int mismatched = 0;

   logic [WIDTH-1:0] m_stk[$];
   logic [WIDTH-1:0] m_q;
   logic             m_ovf;
   logic             m_unf;

   task automatic model_reset();
      m_stk.delete();
      m_q = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   task automatic do_reset();
      bus.push = 0; bus.pop = 0; bus.hold = 0; bus.clear_err = 0; bus.d = '0;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of inputs and advance the reference model by the stack rules.
   task automatic apply(input logic p, input logic po, input logic h,
                        input logic [WIDTH-1:0] dv, input logic clr);
      logic ovf_set, unf_set;
      bus.push = p; bus.pop = po; bus.hold = h; bus.d = dv; bus.clear_err = clr;
      @(posedge clk);
      ovf_set = 1'b0; unf_set = 1'b0;
      if (!h && p && !po) begin
         if (m_stk.size() == DEPTH) ovf_set = 1'b1;
         else m_stk.push_back(dv);
      end else if (!h && po && !p) begin
         if (m_stk.size() == 0) begin
            m_q = '0;
            unf_set = 1'b1;
         end else begin
            m_q = m_stk.pop_back();
         end
      end
      m_ovf = ovf_set | (m_ovf & ~clr);
      m_unf = unf_set | (m_unf & ~clr);
      #1;
      bus.push = 0; bus.pop = 0; bus.hold = 0; bus.clear_err = 0;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if (bus.count !== CW'(0) || bus.q !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
          bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_state: count=%0d q=%h empty=%b full=%b ovf=%b unf=%b, want 0 0 1 0 0 0",
                  bus.count, bus.q, bus.empty, bus.full, bus.overflow, bus.underflow);
      end
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] exp_q [2];
      int exp_cnt [2];
      exp_q[0] = 32'h2222_2222; exp_q[1] = 32'h1111_1111;
      exp_cnt[0] = 1; exp_cnt[1] = 0;
      do_reset();
      apply(1, 0, 0, 32'h1111_1111, 0);
      apply(1, 0, 0, 32'h2222_2222, 0);
      compared++;
      if (bus.count !== CW'(2)) begin
         mismatched++;
         $display("FAIL basic_count_after_push: got %0d want 2", bus.count);
      end
      for (int i = 0; i < 2; i++) begin
         apply(0, 1, 0, '0, 0);
         compared++;
         if (bus.q !== exp_q[i] || bus.count !== CW'(exp_cnt[i])) begin
            mismatched++;
            $display("FAIL basic_pop%0d: q=%h count=%0d want q=%h count=%0d",
                     i, bus.q, bus.count, exp_q[i], exp_cnt[i]);
         end
      end
      compared++;
      if (bus.empty !== 1'b1) begin
         mismatched++;
         $display("FAIL basic_empty_end: got %b want 1", bus.empty);
      end
   endtask

   task automatic test_fill_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) apply(1, 0, 0, WIDTH'(i), 0);
      compared++;
      if (bus.full !== 1'b1 || bus.count !== CW'(DEPTH) || bus.overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL fill_full: full=%b count=%0d ovf=%b want 1 %0d 0", bus.full, bus.count, bus.overflow, DEPTH);
      end
      apply(1, 0, 0, 32'hDEAD_BEEF, 0);
      compared++;
      if (bus.overflow !== 1'b1 || bus.count !== CW'(DEPTH)) begin
         mismatched++;
         $display("FAIL overflow_push: ovf=%b count=%0d want 1 %0d", bus.overflow, bus.count, DEPTH);
      end
      apply(0, 1, 0, '0, 0);
      compared++;
      if (bus.q !== WIDTH'(DEPTH - 1) || bus.count !== CW'(DEPTH - 1) || bus.full !== 1'b0) begin
         mismatched++;
         $display("FAIL overflow_pop: q=%h count=%0d full=%b want q=%h count=%0d full=0",
                  bus.q, bus.count, bus.full, DEPTH - 1, DEPTH - 1);
      end
   endtask

   task automatic test_underflow_clear();
      do_reset();
      apply(1, 0, 0, 32'h3333_3333, 0);
      apply(0, 1, 0, '0, 0);
      apply(0, 1, 0, '0, 0);
      compared++;
      if (bus.underflow !== 1'b1 || bus.q !== '0 || bus.count !== CW'(0)) begin
         mismatched++;
         $display("FAIL underflow_pop: unf=%b q=%h count=%0d want 1 0 0", bus.underflow, bus.q, bus.count);
      end
      apply(0, 0, 0, '0, 1);
      compared++;
      if (bus.underflow !== 1'b0) begin
         mismatched++;
         $display("FAIL underflow_clear: unf=%b want 0", bus.underflow);
      end
      // Error event coinciding with clear must leave the flag set.
      apply(0, 1, 0, '0, 1);
      compared++;
      if (bus.underflow !== 1'b1) begin
         mismatched++;
         $display("FAIL clear_vs_set: unf=%b want 1", bus.underflow);
      end
   endtask

   task automatic test_hold_and_conflict();
      do_reset();
      apply(0, 1, 0, '0, 0);             // underflow=1, q=0
      apply(1, 0, 0, 32'h5555_5555, 0);  // count=1
      apply(1, 0, 1, 32'h7777_7777, 0);
      apply(0, 1, 1, '0, 0);
      compared++;
      if (bus.count !== CW'(1) || bus.q !== '0 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL hold_ignored: count=%0d q=%h unf=%b ovf=%b want 1 0 1 0",
                  bus.count, bus.q, bus.underflow, bus.overflow);
      end
      apply(1, 1, 0, 32'h9999_9999, 0);
      compared++;
      if (bus.count !== CW'(1) || bus.q !== '0 || bus.underflow !== 1'b1 || bus.overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL push_pop_conflict: count=%0d q=%h unf=%b ovf=%b want 1 0 1 0",
                  bus.count, bus.q, bus.underflow, bus.overflow);
      end
      apply(0, 0, 1, '0, 1);
      apply(0, 1, 0, '0, 0);
      compared++;
      if (bus.q !== 32'h5555_5555 || bus.underflow !== 1'b0 || bus.empty !== 1'b1) begin
         mismatched++;
         $display("FAIL hold_clear_then_pop: q=%h unf=%b empty=%b want 55555555 0 1",
                  bus.q, bus.underflow, bus.empty);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      apply(1, 0, 0, 32'hA5A5_A5A5, 0);
      apply(0, 1, 0, '0, 0);
      apply(1, 0, 0, 32'hA5A5_A5A5, 0);
      #2 reset = 1'b1;
      #1;
      compared++;
      if (bus.count !== CW'(0) || bus.q !== '0 || bus.empty !== 1'b1) begin
         mismatched++;
         $display("FAIL async_reset: count=%0d q=%h empty=%b want 0 0 1", bus.count, bus.q, bus.empty);
      end
      // Reset held across an edge with a push pending must suppress it.
      bus.push = 1'b1; bus.d = 32'h1234_5678;
      @(posedge clk); #1;
      compared++;
      if (bus.count !== CW'(0)) begin
         mismatched++;
         $display("FAIL reset_over_push: count=%0d want 0", bus.count);
      end
      bus.push = 1'b0;
      reset = 1'b0;
      model_reset();
      apply(1, 0, 0, 32'hC3C3_C3C3, 0);
      compared++;
      if (bus.count !== CW'(1)) begin
         mismatched++;
         $display("FAIL first_edge_after_reset: count=%0d want 1", bus.count);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 400; n++) begin
         int sel;
         logic p, po, h, clr;
         sel = int'($urandom_range(0, 99));
         p = 0; po = 0;
         if (sel < 45) p = 1;
         else if (sel < 85) po = 1;
         else if (sel < 92) begin p = 1; po = 1; end
         h   = ($urandom_range(0, 9) == 0);
         clr = ($urandom_range(0, 7) == 0);
         apply(p, po, h, WIDTH'($urandom), clr);
         compared++;
         if (bus.count !== CW'(m_stk.size()) || bus.q !== m_q ||
             bus.empty !== (m_stk.size() == 0) || bus.full !== (m_stk.size() == DEPTH) ||
             bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
            mismatched++;
            $display("FAIL random_step%0d: count=%0d q=%h e=%b f=%b ovf=%b unf=%b want %0d %h %b %b %b %b",
                     n, bus.count, bus.q, bus.empty, bus.full, bus.overflow, bus.underflow,
                     m_stk.size(), m_q, m_stk.size() == 0, m_stk.size() == DEPTH, m_ovf, m_unf);
         end
      end
   endtask

   initial begin
      bus.push = 0; bus.pop = 0; bus.hold = 0; bus.clear_err = 0; bus.d = '0;
      model_reset();
      test_reset();
      test_basic();
      test_fill_overflow();
      test_underflow_clear();
      test_hold_and_conflict();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/cpu_stack.md
CPU_STACK -- requirements
Module: cpu_stack

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 128, number of stack entries; power of two, minimum 2.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 push  input  1  push request, driven by the control unit for the PUSH opcode.
REQ-006 pop  input  1  pop request, driven by the control unit for the POP opcode.
REQ-007 hold  input  1  pipeline stall; when 1, push and pop are ignored.
REQ-008 d  input  WIDTH  data to push, taken from the source register.
REQ-009 clear_err  input  1  clears the sticky error flags.
REQ-010 q  output  WIDTH  registered value of the most recently popped word.
REQ-011 empty  output  1  1 when the entry count is 0 (combinational from count).
REQ-012 full  output  1  1 when the entry count equals DEPTH (combinational from count).
REQ-013 overflow  output  1  sticky flag; set on a push while full.
REQ-014 underflow  output  1  sticky flag; set on a pop while empty.
REQ-015 count  output  log2(DEPTH)+1  current number of stored entries.

Function
REQ-016 Storage SHALL be a DEPTH x WIDTH synchronous-write array addressed by a log2(DEPTH)-bit stack pointer sp, with sp = count[log2(DEPTH)-1:0].
REQ-017 An accepted push SHALL require push=1, pop=0, hold=0 and full=0; on that edge it writes mem[sp] <= d and sets count <= count+1.
REQ-018 A push while full (push=1, pop=0, hold=0) SHALL leave memory and count unchanged and set overflow to 1.
REQ-019 An accepted pop SHALL require pop=1, push=0, hold=0 and empty=0; on that edge it sets q <= mem[sp-1] and count <= count-1.
REQ-020 q SHALL become valid on the same rising edge that accepts the pop, with latency 1 cycle from request to visible q.
REQ-021 A pop while empty SHALL leave count unchanged, load q <= 0 and set underflow to 1.
REQ-022 q SHALL hold its value whenever no pop is accepted.
REQ-023 When push=1 and pop=1 in the same cycle, neither operation SHALL be performed, with no state change and no flag change.
REQ-024 When hold=1, push and pop SHALL be ignored entirely, including error-flag updates; clear_err still takes effect.
REQ-025 A pushed word SHALL be readable by a pop in the next cycle; push-then-pop back-to-back returns the pushed d.
REQ-026 Count SHALL never exceed DEPTH nor go below 0; the pointer SHALL never wrap.
REQ-027 clear_err=1 SHALL clear overflow and underflow on the next edge.
REQ-028 When clear_err=1 coincides with a new error event, the flag SHALL be set, because the set takes priority over the clear.
REQ-029 The block SHALL have no state machine beyond count, q and the two flags.
REQ-030 A push and a pop each SHALL be single-cycle operations, with no back-pressure output.

Reset
REQ-031 Asserting reset SHALL immediately clear count, q, overflow and underflow to 0, independent of clk; empty=1 and full=0 follow.
REQ-032 Memory contents SHALL NOT be reset and are undefined after reset.
REQ-033 Reset asserted during the edge of a push or pop SHALL win: no write effect is observable through count or q.
REQ-034 The first edge after reset deasserts SHALL process inputs normally.

Verification
REQ-035 Reset, then push d=0x11111111 and push d=0x22222222, then pop twice -> q=0x22222222 then 0x11111111, count 2,1,0, and empty=1 at the end.
REQ-036 Push DEPTH distinct values (i) -> full=1 and count=DEPTH; one more push with d=0xDEADBEEF -> overflow=1 and count unchanged; pop -> q=DEPTH-1 (not 0xDEADBEEF).
REQ-037 Pop on an empty stack -> underflow=1, q=0, count=0; clear_err=1 for one cycle -> underflow=0.
REQ-038 push=1 with hold=1, and separately push=pop=1 with hold=0 -> count, q and flags unchanged in both cases.
REQ-039 Push 0xA5A5A5A5, then assert reset asynchronously mid-cycle -> count=0, q=0 and empty=1 before the next clk edge.
REQ-040 Simultaneous clear_err=1 and pop on empty -> underflow=1 after the edge.
